// File: rtl/memips_pkg.sv
// Shared types and default sizing for the memory-side blocks.
// Holds the arbiter state encoding and the default widths/starvation limit.
// No logic; imported by the arbiter and its interface.
package memips_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port and memory port signals around mem_arbiter.
// master: requesters + memory model (drive requests, m_rdata, m_ready).
// slave : the arbiter (drives responses and the memory request).
interface mem_arbiter_if import memips_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  localparam int BE_W = DATA_W / 8;

  // fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;

  // data port
  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  // memory port
  logic              m_req;
  logic              m_we;
  logic [BE_W-1:0]   m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ready;

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata, m_ready,
    input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_be, m_addr, m_wdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata, m_ready,
    output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_be, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory port; data wins ties unless
// fetch has waited STARVE_LIMIT data grants. Latency: grant 1 cycle after
// sampling, ack 1 cycle after m_ready; memory backpressure = hold in GRANT.
// Ports: clk, rst (sync, active-high), bus (mem_arbiter_if.slave).
module mem_arbiter import memips_pkg::*; #(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int BE_W     = DATA_W / 8;
  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

  arb_state_t          state;
  logic [STREAK_W-1:0] streak;

  logic              m_req_q;
  logic              m_we_q;
  logic [BE_W-1:0]   m_be_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              i_ack_q;
  logic              d_ack_q;

  // Fetch wins when it is alone, or when it has been passed over
  // STARVE_LIMIT times in a row by the data port.
  logic grant_i;
  assign grant_i = bus.i_req && (!bus.d_req || (streak == LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      streak    <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
    end else begin
      // acks are single-cycle pulses raised on the GRANT->RESP transition
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_i) begin
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_be_q    <= '1;
            m_addr_q  <= bus.i_addr;
            m_wdata_q <= '0;
            streak    <= '0;
            state     <= ST_GRANT_I;
          end else if (bus.d_req) begin
            m_req_q   <= 1'b1;
            m_we_q    <= bus.d_we;
            m_be_q    <= bus.d_be;
            m_addr_q  <= bus.d_addr;
            m_wdata_q <= bus.d_wdata;
            // only count grants that actually made fetch wait
            if (bus.i_req && (streak != LIMIT)) begin
              streak <= streak + 1'b1;
            end
            state     <= ST_GRANT_D;
          end
        end
        ST_GRANT_I: begin
          if (bus.m_ready) begin
            i_rdata_q <= bus.m_rdata;
            i_ack_q   <= 1'b1;
            m_req_q   <= 1'b0;
            state     <= ST_RESP;
          end
        end
        ST_GRANT_D: begin
          if (bus.m_ready) begin
            // stores leave the load-data register untouched
            if (!m_we_q) begin
              d_rdata_q <= bus.m_rdata;
            end
            d_ack_q <= 1'b1;
            m_req_q <= 1'b0;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_be    = m_be_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.i_ack   = i_ack_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.d_ack   = d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with an ack scoreboard and a memory model
// whose read data is derived from the address unless a fixed word is forced.
module tb_mem_arbiter;
  import memips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          port;   // 0 = fetch, 1 = data
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mreq_cycles = 0;
  int i_ack_cnt   = 0;
  int d_ack_cnt   = 0;

  bit          use_fixed   = 1'b0;
  logic [31:0] fixed_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // memory model
  always_comb bus.m_rdata = use_fixed ? fixed_rdata : {bus.m_addr[15:0], 16'hA5A5};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'hA5A5};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every ack must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_req) mreq_cycles++;
      if (bus.i_ack) i_ack_cnt++;
      if (bus.d_ack) d_ack_cnt++;
      if (bus.i_ack && bus.d_ack) chk("dual_ack", 64'(2'b11), 64'(2'b01));
      if (bus.i_ack || bus.d_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 64'({bus.i_ack, bus.d_ack}), 64'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_port", 64'(bus.d_ack), 64'(e.port));
          chk("sb_rdata", 64'(e.port ? bus.d_rdata : bus.i_rdata), 64'(e.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string tag, output bit port, output int at_cyc);
    bit seen;
    seen = 1'b0;
    port = 1'b0;
    at_cyc = 0;
    for (int n = 0; n < 12 && !seen; n++) begin
      tick();
      if (bus.i_ack || bus.d_ack) begin
        seen   = 1'b1;
        port   = bus.d_ack;
        at_cyc = cyc;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed=no ack expected=ack within 12 cycles", tag);
    end
  endtask

  initial begin
    bit p;
    int c0, ca, cb, cc;
    int snap_i, snap_d;
    bit          exp_order [6];
    logic [2:0]  exp_streak[6];

    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_ready = 0;

    // ---- reset state
    rst = 1;
    tick(); tick();
    chk("rst_m_req",   64'(bus.m_req),   0);
    chk("rst_m_be",    64'(bus.m_be),    0);
    chk("rst_m_addr",  64'(bus.m_addr),  0);
    chk("rst_i_rdata", 64'(bus.i_rdata), 0);
    chk("rst_d_rdata", 64'(bus.d_rdata), 0);
    chk("rst_streak",  64'(dut.streak),  0);
    chk("rst_state",   64'(dut.state),   64'(ST_IDLE));
    rst = 0;
    tick();

    // ---- single fetch, zero wait
    use_fixed = 1; fixed_rdata = 32'h2408_0005;
    bus.m_ready = 1;
    bus.i_req = 1; bus.i_addr = 32'h0000_0040;
    c0 = cyc;
    exp_q.push_back('{1'b0, 32'h2408_0005});
    tick();
    chk("f1_m_req",  64'(bus.m_req),  1);
    chk("f1_m_we",   64'(bus.m_we),   0);
    chk("f1_m_be",   64'(bus.m_be),   64'hF);
    chk("f1_m_addr", 64'(bus.m_addr), 64'h40);
    wait_ack("f1_ack", p, ca);
    bus.i_req = 0;
    chk("f1_port",    64'(p), 0);
    chk("f1_latency", 64'(ca - c0), 2);
    tick();
    chk("f1_idle",    64'(dut.state), 64'(ST_IDLE));
    chk("f1_ack_low", 64'(bus.i_ack), 0);

    // ---- data write with 3 wait cycles
    use_fixed = 0;
    bus.m_ready = 0;
    mreq_cycles = 0;
    snap_d = d_ack_cnt;
    bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011;
    bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
    exp_q.push_back('{1'b1, 32'h0});
    tick();
    for (int w = 0; w < 3; w++) begin
      chk("wr_m_req",   64'(bus.m_req),   1);
      chk("wr_m_we",    64'(bus.m_we),    1);
      chk("wr_m_be",    64'(bus.m_be),    64'h3);
      chk("wr_m_addr",  64'(bus.m_addr),  64'h100);
      chk("wr_m_wdata", 64'(bus.m_wdata), 64'hDEAD_BEEF);
      tick();
    end
    bus.m_ready = 1;
    wait_ack("wr_ack", p, ca);
    bus.d_req = 0; bus.m_ready = 0;
    chk("wr_port", 64'(p), 1);
    tick(); tick();
    chk("wr_mreq_cycles", 64'(mreq_cycles), 4);
    chk("wr_ack_once",    64'(d_ack_cnt - snap_d), 1);
    chk("wr_d_rdata",     64'(bus.d_rdata), 0);

    // ---- simultaneous requests, starvation limit
    exp_order  = '{1, 1, 1, 1, 0, 1};
    exp_streak = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    for (int k = 0; k < 6; k++)
      exp_q.push_back('{exp_order[k], exp_order[k] ? mem_word(32'h2000) : mem_word(32'h1000)});
    bus.m_ready = 1;
    bus.i_req = 1; bus.i_addr = 32'h1000;
    bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h2000;
    for (int k = 0; k < 6; k++) begin
      wait_ack($sformatf("arb_ack%0d", k), p, ca);
      chk($sformatf("arb_order%0d", k),  64'(p),          64'(exp_order[k]));
      chk($sformatf("arb_streak%0d", k), 64'(dut.streak), 64'(exp_streak[k]));
    end
    bus.i_req = 0; bus.d_req = 0;
    tick(); tick();

    // ---- back-to-back fetches, one transfer per 3 cycles
    for (int k = 0; k < 3; k++) exp_q.push_back('{1'b0, mem_word(32'h300)});
    bus.i_req = 1; bus.i_addr = 32'h300;
    wait_ack("b2b_ack0", p, ca);
    wait_ack("b2b_ack1", p, cb);
    wait_ack("b2b_ack2", p, cc);
    bus.i_req = 0;
    chk("b2b_gap1", 64'(cb - ca), 3);
    chk("b2b_gap2", 64'(cc - cb), 3);
    tick(); tick();

    // ---- reset in the second wait cycle of a data read
    bus.m_ready = 0;
    snap_d = d_ack_cnt;
    bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h400;
    tick();
    chk("ab_m_req_wait1", 64'(bus.m_req), 1);
    tick();
    rst = 1;
    tick();
    chk("ab_m_req",   64'(bus.m_req),   0);
    chk("ab_m_we",    64'(bus.m_we),    0);
    chk("ab_m_be",    64'(bus.m_be),    0);
    chk("ab_m_addr",  64'(bus.m_addr),  0);
    chk("ab_m_wdata", 64'(bus.m_wdata), 0);
    chk("ab_i_rdata", 64'(bus.i_rdata), 0);
    chk("ab_d_rdata", 64'(bus.d_rdata), 0);
    chk("ab_acks",    64'({bus.i_ack, bus.d_ack}), 0);
    chk("ab_streak",  64'(dut.streak),  0);
    rst = 0; bus.d_req = 0;
    bus.m_ready = 1;
    tick(); tick(); tick();
    chk("ab_no_d_ack", 64'(d_ack_cnt - snap_d), 0);
    exp_q.push_back('{1'b0, mem_word(32'h500)});
    bus.i_req = 1; bus.i_addr = 32'h500;
    c0 = cyc;
    wait_ack("ab_fetch_ack", p, ca);
    bus.i_req = 0;
    chk("ab_fetch_port",    64'(p), 0);
    chk("ab_fetch_latency", 64'(ca - c0), 2);
    tick(); tick();

    // ---- m_ready pulsed while idle
    snap_i = i_ack_cnt; snap_d = d_ack_cnt;
    bus.m_ready = 1;
    tick(); tick();
    bus.m_ready = 0;
    tick();
    chk("idle_state", 64'(dut.state), 64'(ST_IDLE));
    chk("idle_m_req", 64'(bus.m_req), 0);
    chk("idle_acks",  64'((i_ack_cnt - snap_i) + (d_ack_cnt - snap_d)), 0);

    chk("sb_drained", 64'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all ports.
REQ-002 Parameter DATA_W, default 32: data width; byte-enable width is DATA_W/8.
REQ-003 Parameter STARVE_LIMIT, default 4: maximum number of consecutive data grants while fetch waits.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: synchronous reset, active-high.
REQ-006 Fetch request ports: i_req (input, 1, fetch read request) and i_addr (input, ADDR_W, fetch address).
REQ-007 Fetch response ports: i_rdata (output, DATA_W, fetched word) and i_ack (output, 1, one-cycle completion pulse).
REQ-008 Data request ports: d_req (input, 1), d_we (input, 1, 1 = write), d_be (input, DATA_W/8, byte enables), d_addr (input, ADDR_W) and d_wdata (input, DATA_W).
REQ-009 Data response ports: d_rdata (output, DATA_W, load data) and d_ack (output, 1, one-cycle completion pulse).
REQ-010 Memory request ports: m_req (output, 1), m_we (output, 1), m_be (output, DATA_W/8), m_addr (output, ADDR_W) and m_wdata (output, DATA_W).
REQ-011 Memory response ports: m_rdata (input, DATA_W) and m_ready (input, 1, transfer completes this cycle).

Function
REQ-012 FSM states and order: IDLE -> GRANT_I or GRANT_D -> RESP -> IDLE.
REQ-013 Request sampling:
- Requests are sampled only in IDLE.
- On a grant, the requester's address, we, be and wdata are latched.
- The FSM then moves to the matching GRANT state.
REQ-014 Fetch grants always use m_we=0 and m_be=all ones.
REQ-015 GRANT behaviour:
- m_req=1, driven from latched fields only.
- Stays in GRANT until m_ready=1.
- Any number of wait cycles is allowed.
REQ-016 On m_ready in GRANT:
- m_rdata is captured into the granted port's rdata register, except for data writes, where d_rdata is unchanged.
- The FSM goes to RESP.
REQ-017 RESP behaviour:
- m_req=0.
- The granted port's ack=1 for exactly this one cycle.
- Next state is IDLE.
REQ-018 Minimum latency: request sampled in cycle 0, m_req in cycle 1, ack in cycle 2 if m_ready is already high in cycle 1, IDLE in cycle 3.
REQ-019 A requester holds req and its fields stable until ack. A req still high in the IDLE cycle after ack is a new request.
REQ-020 Priority when both requests are pending in IDLE:
- Data is granted.
- Fetch is granted instead if streak==STARVE_LIMIT.
REQ-021 A single pending request is granted regardless of streak.
REQ-022 streak counter:
- Increments, saturating at STARVE_LIMIT, on a data grant while i_req=1.
- Clears on any fetch grant.
- Holds otherwise.
REQ-023 m_ready is ignored whenever m_req=0.
REQ-024 i_rdata and d_rdata hold their last captured value between acks.
REQ-025 i_ack and d_ack are never asserted in the same cycle.

Reset
REQ-026 On rst:
- State goes to IDLE.
- streak=0.
- m_req, m_we, m_be, m_addr, m_wdata, i_ack, d_ack, i_rdata and d_rdata all go to 0.
REQ-027 Reset during GRANT or RESP aborts the transfer: m_req is 0 in the cycle after rst is sampled, and no ack is issued for the aborted request.
REQ-028 Requests are not sampled while rst=1.

Structure
REQ-029 The state enum arb_state_t and the default widths and limit belong in the shared memips_pkg.
REQ-030 No sub-module: FSM, latches and streak counter are inline in mem_arbiter.

Verification
REQ-031 Single fetch:
- Stimulus: i_req, i_addr=0x0000_0040, m_ready tied to 1, m_rdata=0x2408_0005.
- Response: m_req in cycle 1, i_ack in cycle 2, i_rdata=0x2408_0005.
REQ-032 Data write with 3 wait cycles:
- Stimulus: d_we=1, d_be=0011, d_addr=0x100, d_wdata=0xDEAD_BEEF.
- Response: m_req held 4 cycles with stable fields, d_ack once, d_rdata unchanged.
REQ-033 Simultaneous requests with i_req held continuously and d_req reissued:
- Expected grant order: D, D, D, D, I, D.
- streak reads 4 before the I grant and 0 after it.
REQ-034 Back-to-back fetches with i_req held high: new grant in the IDLE cycle after each ack, giving one transfer per 3 cycles with zero wait.
REQ-035 rst asserted in the second wait cycle of a data read:
- m_req=0 in the next cycle and no d_ack.
- All outputs 0.
- A fetch issued after reset completes normally.
REQ-036 m_ready pulsed high while in IDLE: no state change, no ack.
